// File: rtl/store_addr_data_join_pkg.sv
// Shared types and helpers for the store address/data join and its FIFOs.
package store_addr_data_join_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 4;

   // Encoding matches {push, pop} so the FIFO can cast its qualified strobes directly.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifoOp_e;

   function automatic int unsigned nextIndex(input int unsigned idx, input int unsigned depth);
      return (idx == depth - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular-buffer FIFO holding one side (address or data) of the store join.
module store_fifo
   import store_addr_data_join_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           in,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;
   fifoOp_e          op;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Qualified locally too, so a careless caller can never over- or under-run the occupancy.
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign op     = fifoOp_e'({doPush, doPop});
   assign head   = mem[rdPtr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= PTR_W'(nextIndex(32'(wrPtr), DEPTH));
         if (doPop)  rdPtr <= PTR_W'(nextIndex(32'(rdPtr), DEPTH));
         case (op)
            OP_PUSH: count <= count + CNT_W'(1);
            OP_POP:  count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= in;
   end

endmodule

// File: rtl/store_addr_data_join.sv
// Joins independently arriving store address and data into one paired request stream.
module store_addr_data_join
   import store_addr_data_join_pkg::*;
#(
   parameter int DATA_TYPE = DEFAULT_WIDTH,
   parameter int ADDR_TYPE = DEFAULT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_TYPE-1:0]       addrIn,
   input  logic                       addrIn_valid,
   output logic                       addrIn_ready,
   input  logic [DATA_TYPE-1:0]       dataIn,
   input  logic                       dataIn_valid,
   output logic                       dataIn_ready,
   output logic [ADDR_TYPE-1:0]       stAddr,
   output logic                       stAddr_valid,
   input  logic                       stAddr_ready,
   output logic [DATA_TYPE-1:0]       stData,
   output logic                       stData_valid,
   input  logic                       stData_ready,
   output logic [$clog2(DEPTH+1)-1:0] pairCount
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [CNT_W-1:0] addrCount;
   logic [CNT_W-1:0] dataCount;
   logic             addrFull;
   logic             addrEmpty;
   logic             dataFull;
   logic             dataEmpty;
   logic             pairValid;
   logic             pairPop;

   // Input readiness looks only at occupancy, keeping stAddr_ready off the input timing path.
   assign addrIn_ready = !addrFull;
   assign dataIn_ready = !dataFull;

   assign pairValid    = !addrEmpty && !dataEmpty;
   assign pairPop      = pairValid && stAddr_ready;
   assign stAddr_valid = pairValid;
   assign stData_valid = pairValid;
   assign pairCount    = (addrCount < dataCount) ? addrCount : dataCount;

   store_fifo #(.WIDTH(ADDR_TYPE), .DEPTH(DEPTH)) addrFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (addrIn_valid && addrIn_ready),
      .pop   (pairPop),
      .in    (addrIn),
      .head  (stAddr),
      .count (addrCount),
      .full  (addrFull),
      .empty (addrEmpty)
   );

   store_fifo #(.WIDTH(DATA_TYPE), .DEPTH(DEPTH)) dataFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dataIn_valid && dataIn_ready),
      .pop   (pairPop),
      .in    (dataIn),
      .head  (stData),
      .count (dataCount),
      .full  (dataFull),
      .empty (dataEmpty)
   );

   // The controller drives one ready to both channels; a split ready would desynchronise the pair.
   readyTied: assert property (@(posedge clk) disable iff (rst)
      stAddr_valid |-> (stData_ready == stAddr_ready));

endmodule

// File: tb/tb_store_addr_data_join.sv
// Bench for store_addr_data_join: directed vector table, DEPTH=1 sequence, random run against a queue model.
module tb_store_addr_data_join;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addrIn, dataIn;
   logic        addrInValid, dataInValid, stAddrReady;
   logic        addrInReady, dataInReady, stAddrValid, stDataValid;
   logic [31:0] stAddr, stData;
   logic [2:0]  pairCount;

   logic [31:0] d1AddrIn, d1DataIn, d1StAddr, d1StData;
   logic        d1AddrValid, d1DataValid, d1StReady;
   logic        d1AddrReady, d1DataReady, d1StAddrValid, d1StDataValid;
   logic [0:0]  d1PairCount;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   store_addr_data_join #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .addrIn(addrIn), .addrIn_valid(addrInValid), .addrIn_ready(addrInReady),
      .dataIn(dataIn), .dataIn_valid(dataInValid), .dataIn_ready(dataInReady),
      .stAddr(stAddr), .stAddr_valid(stAddrValid), .stAddr_ready(stAddrReady),
      .stData(stData), .stData_valid(stDataValid), .stData_ready(stAddrReady),
      .pairCount(pairCount)
   );

   store_addr_data_join #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(1)) dut1 (
      .clk(clk), .rst(rst),
      .addrIn(d1AddrIn), .addrIn_valid(d1AddrValid), .addrIn_ready(d1AddrReady),
      .dataIn(d1DataIn), .dataIn_valid(d1DataValid), .dataIn_ready(d1DataReady),
      .stAddr(d1StAddr), .stAddr_valid(d1StAddrValid), .stAddr_ready(d1StReady),
      .stData(d1StData), .stData_valid(d1StDataValid), .stData_ready(d1StReady),
      .pairCount(d1PairCount)
   );

   typedef struct {
      logic        rst;
      logic        aV;
      logic [31:0] a;
      logic        dV;
      logic [31:0] d;
      logic        rdy;
      logic        eV;
      logic [31:0] eA;
      logic [31:0] eD;
      logic        eAR;
      logic        eDR;
      int          ePc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic aV, logic [31:0] a, logic dV, logic [31:0] d, logic rdy,
                               logic eV, logic [31:0] eA, logic [31:0] eD, logic eAR, logic eDR, int ePc);
      vec_t v;
      v.rst = r; v.aV = aV; v.a = a; v.dV = dV; v.d = d; v.rdy = rdy;
      v.eV = eV; v.eA = eA; v.eD = eD; v.eAR = eAR; v.eDR = eDR; v.ePc = ePc;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge; inputs set here apply at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] aq[$];
   logic [31:0] dq[$];

   initial begin
      rst = 1'b1;
      addrIn = '0; dataIn = '0; addrInValid = 1'b0; dataInValid = 1'b0; stAddrReady = 1'b0;
      d1AddrIn = '0; d1DataIn = '0; d1AddrValid = 1'b0; d1DataValid = 1'b0; d1StReady = 1'b0;
      tick();
      tick();

      // Each row: inputs driven into one edge, expected outputs seen right after that edge.
      vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 1, 'h10,    1, 'hAA,    1, 1, 'h10,    'hAA,    1, 1, 1));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 1, 'h1,     0, 0,       1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 1, 'h2,     0, 0,       1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 1, 'h3,     0, 0,       1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 0, 0,       1, 'hD1,    0, 1, 'h1,     'hD1,    1, 1, 1));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 0, 0,       1, 'hD2,    0, 1, 'h2,     'hD2,    1, 1, 1));
      vecs.push_back(mk(0, 0, 0,       1, 'hD3,    1, 1, 'h3,     'hD3,    1, 1, 1));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0, 0,       0,       1, 1, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 1, 'h100 + i, 1, 'h200 + i, 0, 1, 'h100, 'h200, i < 3, i < 3, i + 1));
      vecs.push_back(mk(0, 1, 'h1FF,   1, 'h2FF,   0, 1, 'h100,   'h200,   0, 0, 4));
      vecs.push_back(mk(0, 1, 'h1FF,   1, 'h2FF,   1, 1, 'h101,   'h201,   1, 1, 3));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 1, 'h102,   'h202,   1, 1, 2));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 1, 'h103,   'h203,   1, 1, 1));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 1, 'h31,    1, 'hC1,    0, 1, 'h31,    'hC1,    1, 1, 1));
      vecs.push_back(mk(0, 1, 'h32,    1, 'hC2,    0, 1, 'h31,    'hC1,    1, 1, 2));
      vecs.push_back(mk(0, 1, 'h33,    1, 'hC3,    0, 1, 'h31,    'hC1,    1, 1, 3));
      vecs.push_back(mk(1, 1, 'h77,    1, 'h88,    1, 0, 0,       0,       1, 1, 0));
      vecs.push_back(mk(0, 1, 'h41,    1, 'hD4,    0, 1, 'h41,    'hD4,    1, 1, 1));
      vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0, 0,       0,       1, 1, 0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         addrInValid = vecs[i].aV; addrIn = vecs[i].a;
         dataInValid = vecs[i].dV; dataIn = vecs[i].d;
         stAddrReady = vecs[i].rdy;
         tick();
         check($sformatf("vec%0d.addrValid", i), stAddrValid, vecs[i].eV);
         check($sformatf("vec%0d.dataValid", i), stDataValid, vecs[i].eV);
         check($sformatf("vec%0d.addrReady", i), addrInReady, vecs[i].eAR);
         check($sformatf("vec%0d.dataReady", i), dataInReady, vecs[i].eDR);
         check($sformatf("vec%0d.pairCount", i), pairCount, vecs[i].ePc);
         if (vecs[i].eV) begin
            check($sformatf("vec%0d.stAddr", i), stAddr, vecs[i].eA);
            check($sformatf("vec%0d.stData", i), stData, vecs[i].eD);
         end
      end
      rst = 1'b0;

      // Streaming: one pair in and one pair out on every edge.
      stAddrReady = 1'b1;
      for (int k = 0; k < 8; k++) begin
         addrInValid = 1'b1; addrIn = 'h500 + k;
         dataInValid = 1'b1; dataIn = 'h600 + k;
         tick();
         check($sformatf("stream%0d.valid", k), stAddrValid, 1'b1);
         check($sformatf("stream%0d.stAddr", k), stAddr, 'h500 + k);
         check($sformatf("stream%0d.stData", k), stData, 'h600 + k);
         check($sformatf("stream%0d.pairCount", k), pairCount, 1);
      end
      addrInValid = 1'b0; dataInValid = 1'b0;
      tick();
      check("stream.drained", stAddrValid, 1'b0);

      // DEPTH=1: continuous offer must give exactly one pair every second cycle.
      begin
         int aIdx, dIdx, popIdx, lastPop;
         logic accA, accD;
         aIdx = 0; dIdx = 0; popIdx = 0; lastPop = -1;
         d1StReady = 1'b1;
         d1AddrValid = 1'b1; d1DataValid = 1'b1;
         d1AddrIn = 'h700; d1DataIn = 'h800;
         for (int cyc = 0; cyc < 24; cyc++) begin
            accA = d1AddrReady;
            accD = d1DataReady;
            tick();
            if (accA) aIdx++;
            if (accD) dIdx++;
            d1AddrIn = 'h700 + aIdx;
            d1DataIn = 'h800 + dIdx;
            if (d1StAddrValid) begin
               check($sformatf("d1.pop%0d.stAddr", popIdx), d1StAddr, 'h700 + popIdx);
               check($sformatf("d1.pop%0d.stData", popIdx), d1StData, 'h800 + popIdx);
               if (lastPop >= 0) check($sformatf("d1.pop%0d.gap", popIdx), cyc - lastPop, 2);
               lastPop = cyc;
               popIdx++;
            end
         end
         check("d1.popTotal", popIdx, 12);
         d1AddrValid = 1'b0; d1DataValid = 1'b0;
      end

      // Random traffic compared against a queue model of the two buffers.
      rst = 1'b1;
      addrInValid = 1'b0; dataInValid = 1'b0; stAddrReady = 1'b0;
      tick();
      rst = 1'b0;
      aq.delete();
      dq.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int na, nd, rdyPct;
         logic mv;
         na = aq.size();
         nd = dq.size();
         mv = (na > 0) && (nd > 0);
         check("rnd.addrValid", stAddrValid, mv);
         check("rnd.dataValid", stDataValid, mv);
         check("rnd.addrReady", addrInReady, na < DEPTH);
         check("rnd.dataReady", dataInReady, nd < DEPTH);
         check("rnd.pairCount", pairCount, (na < nd) ? na : nd);
         if (mv) begin
            check("rnd.stAddr", stAddr, aq[0]);
            check("rnd.stData", stData, dq[0]);
         end
         rdyPct = ((cyc / 256) % 2 == 1) ? 80 : 25;
         rst = ($urandom_range(0, 299) == 0);
         addrInValid = ($urandom_range(0, 99) < 55);
         dataInValid = ($urandom_range(0, 99) < 55);
         addrIn = $urandom;
         dataIn = $urandom;
         stAddrReady = ($urandom_range(0, 99) < rdyPct);
         if (rst) begin
            aq.delete();
            dq.delete();
         end else begin
            if (mv && stAddrReady) begin
               void'(aq.pop_front());
               void'(dq.pop_front());
            end
            if (addrInValid && na < DEPTH) aq.push_back(addrIn);
            if (dataInValid && nd < DEPTH) dq.push_back(dataIn);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/store_addr_data_join.md
# store_addr_data_join

Upstream companion of the load-less memory controller. It accepts one store's address and data on two independent handshake channels. Each channel is buffered in its own small FIFO, and the block presents a paired {address, data} request whose single valid condition covers both channels. This matches the controller's store port: it samples address-valid only and drives one ready signal to both channels. Without this block, a circuit that produces address and data in different cycles would either lose data or deadlock.

## Interface
Parameters:
- DATA_TYPE, 32, store data width
- ADDR_TYPE, 32, store address width
- DEPTH, 4, entries per FIFO; must be ≥ 1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- addrIn  in  ADDR_TYPE  store address from the circuit
- addrIn_valid  in  1  address offered
- addrIn_ready  out  1  address FIFO can accept
- dataIn  in  DATA_TYPE  store data from the circuit
- dataIn_valid  in  1  data offered
- dataIn_ready  out  1  data FIFO can accept
- stAddr  out  ADDR_TYPE  head of the address FIFO
- stAddr_valid  out  1  a pair is available
- stAddr_ready  in  1  controller accepts the pair
- stData  out  DATA_TYPE  head of the data FIFO
- stData_valid  out  1  identical to stAddr_valid
- stData_ready  in  1  ignored except in assertions; the controller ties it to stAddr_ready
- pairCount  out  $clog2(DEPTH+1)  number of complete pairs buffered (min of both occupancies)

## Operation
Each FIFO is a circular buffer with a write pointer, a read pointer and an occupancy counter.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Occupancy ranges 0..DEPTH.

Push:
- Address push happens when addrIn_valid && addrIn_ready.
- Data push happens when dataIn_valid && dataIn_ready.
- The two pushes are independent and may occur in the same cycle.

Ready:
- addrIn_ready = (addrCount != DEPTH); dataIn_ready = (dataCount != DEPTH).
- Ready depends only on occupancy. There is no combinational path from stAddr_ready to the input ready signals.

Output valid:
- stAddr_valid = stData_valid = (addrCount != 0) && (dataCount != 0).
- stAddr and stData are the FIFO heads and stay stable while valid is held.

Pop:
- A pop happens when stAddr_valid && stAddr_ready.
- A pop removes one entry from both FIFOs in the same cycle.

Counter update on a simultaneous push and pop on one FIFO:
- The occupancy is unchanged.
- Both pointers advance.

Ordering:
- Pairing is strictly FIFO: the k-th address pushed is paired with the k-th data pushed.

Unbalanced arrival:
- Extra entries wait on whichever side arrived first.
- That side stalls only when it is full.

Full on one side only: that side's ready drops; the other side keeps accepting until it is also full.

## Timing
- Reset values:
  - all pointers and counters 0
  - stAddr_valid = stData_valid = 0
  - addrIn_ready = dataIn_ready = 1 (for DEPTH ≥ 1)
  - pairCount = 0
  - stAddr and stData undefined (RAM contents are not reset)
- Latency:
  - A pair completed by a push in cycle t is valid from cycle t+1.
  - There is no same-cycle bypass.
- Throughput: one pair per cycle in steady state when DEPTH ≥ 2. With DEPTH = 1, the maximum rate is one pair every 2 cycles.
- Freed entry: a pop in cycle t frees an entry that is visible as ready in cycle t+1. A full FIFO does not accept a push in the same cycle as a pop.
- Reset mid-operation:
  - On the cycle rst is sampled high, all buffered entries are discarded and no pop is reported.
  - Outputs take their reset values from the next cycle.
  - rst has priority over push and pop.

## Structure
- Sub-module store_fifo (WIDTH, DEPTH), instantiated twice:
  - inputs: push, pop, in
  - outputs: head, count, full, empty
  - the top-level block holds only the join logic and the min for pairCount
- Shared package: not required. Pointer and counter widths derive from $clog2(DEPTH) and $clog2(DEPTH+1) locally.

## Test plan
- Reset, then push addr 0x10 and data 0xAA in the same cycle (t0):
  - stAddr_valid rises at t1 with stAddr=0x10 and stData=0xAA
  - with stAddr_ready=1 it drops at t2
  - pairCount goes 0→1→0
- Push addrs 0x1, 0x2, 0x3 over 3 cycles with no data:
  - stAddr_valid stays 0
  - then push data 0xD1: valid rises the next cycle with pair (0x1, 0xD1)
  - pairCount = 1; address occupancy remains 3 until the pop
- DEPTH=4, stAddr_ready=0, push 4 addrs and 4 data:
  - both readies low after the 4th push
  - a 5th offer is not accepted
  - raise stAddr_ready for 1 cycle: one pop, and both readies high the next cycle
- Continuous push of both channels with stAddr_ready=1:
  - one pair per cycle sustained
  - pairs emerge in order 0..N-1 with matching data
- Assert rst while 3 pairs are buffered:
  - next cycle valid=0, pairCount=0, both readies=1
  - a subsequent push pair emerges unmixed with the pre-reset entries
- DEPTH=1, continuous offer:
  - pairs emerge every second cycle
  - no entry is duplicated or dropped
